vram_slot_arbiter: RTL and testbench

//  Time-slot arbiter for the single-port video RAM shared by the pixel fetch path and game logic.

---
 rtl/vram_slot_arbiter.sv | 143 ++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// rtl/vram_slot_arbiter.sv - four-phase VRAM slot arbiter: display read in phase 0, A/B round-robin in phases 1-3
// Build option: define SLOT_RECLAIM_EN to offer an idle phase-0 slot to A/B.
module vram_slot_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk100_i,
    input  logic              rst_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_vld_o,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_gnt_o,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              a_rvld_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_gnt_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              b_rvld_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        phase_o
);

    localparam logic [1:0] ID_DISP = 2'd0;
    localparam logic [1:0] ID_A    = 2'd1;
    localparam logic [1:0] ID_B    = 2'd2;

    logic [1:0]        phase;
    logic              rr_b;
    logic              disp_win;
    logic              slot_open;
    logic              issue_rd;
    logic [1:0]        issue_id;
    logic [2:0]        tag_pipe [0:MEM_LAT];
    logic [2:0]        ret_tag;
    logic [DATA_W-1:0] disp_hold;
    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;

    assign disp_win = (phase == 2'd0) && disp_req_i;

`ifdef SLOT_RECLAIM_EN
    assign slot_open = !disp_win;
`else
    assign slot_open = (phase != 2'd0);
`endif

    // rr_b set means B is preferred when both request (A was granted last)
    assign a_gnt_o = slot_open && a_req_i && (!b_req_i || !rr_b);
    assign b_gnt_o = slot_open && b_req_i && (!a_req_i || rr_b);

    always_comb begin
        issue_rd = 1'b0;
        issue_id = ID_DISP;
        if (disp_win) begin
            issue_rd = 1'b1;
        end else if (a_gnt_o) begin
            issue_rd = !a_we_i;
            issue_id = ID_A;
        end else if (b_gnt_o) begin
            issue_rd = !b_we_i;
            issue_id = ID_B;
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            phase       <= 2'd0;
            rr_b        <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            disp_hold   <= '0;
            a_hold      <= '0;
            b_hold      <= '0;
            for (int i = 0; i <= MEM_LAT; i++) begin
                tag_pipe[i] <= 3'b000;
            end
        end else begin
            phase <= phase + 2'd1;
            if (a_gnt_o) begin
                rr_b <= 1'b1;
            end else if (b_gnt_o) begin
                rr_b <= 1'b0;
            end

            mem_en_o <= disp_win || a_gnt_o || b_gnt_o;
            mem_we_o <= (a_gnt_o && a_we_i) || (b_gnt_o && b_we_i);
            if (disp_win) begin
                mem_addr_o <= disp_addr_i;
            end else if (a_gnt_o) begin
                mem_addr_o  <= a_addr_i;
                mem_wdata_o <= a_wdata_i;
            end else if (b_gnt_o) begin
                mem_addr_o  <= b_addr_i;
                mem_wdata_o <= b_wdata_i;
            end

            // stage k describes the access whose data is on mem_rdata_i k+1 clocks after issue
            tag_pipe[0] <= {issue_rd, issue_id};
            for (int i = 1; i <= MEM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            if (disp_vld_o) begin
                disp_hold <= mem_rdata_i;
            end
            if (a_rvld_o) begin
                a_hold <= mem_rdata_i;
            end
            if (b_rvld_o) begin
                b_hold <= mem_rdata_i;
            end
        end
    end

    assign ret_tag = tag_pipe[MEM_LAT];

    assign disp_vld_o = ret_tag[2] && (ret_tag[1:0] == ID_DISP);
    assign a_rvld_o   = ret_tag[2] && (ret_tag[1:0] == ID_A);
    assign b_rvld_o   = ret_tag[2] && (ret_tag[1:0] == ID_B);

    // Data is bypassed on the strobe cycle and held from the capture register afterwards
    assign disp_data_o = disp_vld_o ? mem_rdata_i : disp_hold;
    assign a_rdata_o   = a_rvld_o   ? mem_rdata_i : a_hold;
    assign b_rdata_o   = b_rvld_o   ? mem_rdata_i : b_hold;

    assign phase_o = phase;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb/tb_vram_slot_arbiter.sv - scoreboard bench for vram_slot_arbiter at MEM_LAT 1 and 3 with shared stimulus
module tb_vram_slot_arbiter;

`ifdef SLOT_RECLAIM_EN
    localparam bit RECLAIM = 1'b1;
`else
    localparam bit RECLAIM = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [7:0]  data;
        logic [31:0] due;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req, a_req, a_we, b_req, b_we;
    logic [13:0] disp_addr, a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;

    logic [7:0]  disp_data [2];
    logic        disp_vld  [2];
    logic        a_gnt     [2];
    logic [7:0]  a_rdata   [2];
    logic        a_rvld    [2];
    logic        b_gnt     [2];
    logic [7:0]  b_rdata   [2];
    logic        b_rvld    [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [13:0] mem_addr  [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];
    logic [1:0]  phase     [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vram_slot_arbiter #(.ADDR_W(14), .DATA_W(8), .MEM_LAT(1)) u_lat1 (
        .clk100_i(clk), .rst_i(rst),
        .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_data_o(disp_data[0]), .disp_vld_o(disp_vld[0]),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt[0]), .a_rdata_o(a_rdata[0]), .a_rvld_o(a_rvld[0]),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_gnt_o(b_gnt[0]), .b_rdata_o(b_rdata[0]), .b_rvld_o(b_rvld[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .phase_o(phase[0])
    );

    vram_slot_arbiter #(.ADDR_W(14), .DATA_W(8), .MEM_LAT(3)) u_lat3 (
        .clk100_i(clk), .rst_i(rst),
        .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_data_o(disp_data[1]), .disp_vld_o(disp_vld[1]),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt[1]), .a_rdata_o(a_rdata[1]), .a_rvld_o(a_rvld[1]),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_gnt_o(b_gnt[1]), .b_rdata_o(b_rdata[1]), .b_rvld_o(b_rvld[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .phase_o(phase[1])
    );

    function automatic logic [7:0] dflt(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    // RAM models, one per DUT, driven only by each DUT's mem_* outputs
    bit   [7:0] ram   [2][16384];
    bit         ram_v [2][16384];
    logic [7:0] rp1;
    logic [7:0] rp3 [3];

    function automatic logic [7:0] ram_rd(input int k, input logic [13:0] a);
        return ram_v[k][a] ? ram[k][a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] && mem_we[k]) begin
                ram[k][mem_addr[k]]   <= mem_wdata[k];
                ram_v[k][mem_addr[k]] <= 1'b1;
            end
        end
        rp1    <= (mem_en[0] && !mem_we[0]) ? ram_rd(0, mem_addr[0]) : 8'h00;
        rp3[0] <= (mem_en[1] && !mem_we[1]) ? ram_rd(1, mem_addr[1]) : 8'h00;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mem_rdata[0] = rp1;
    assign mem_rdata[1] = rp3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model state
    bit   [7:0] sh   [16384];
    bit         sh_v [16384];
    logic [1:0] ph_m = 2'd0;
    logic       rr_m = 1'b0;
    ent_t       q0 [$];
    ent_t       q1 [$];
    logic [7:0] held [2][3];
    logic       exp_en = 1'b0, exp_we = 1'b0;
    logic [13:0] exp_addr = '0;
    logic [7:0]  exp_wd = '0;

    function automatic logic [7:0] sh_rd(input logic [13:0] a);
        return sh_v[a] ? sh[a] : dflt(a);
    endfunction

    task automatic push_rd(input logic [1:0] id, input logic [13:0] a);
        q0.push_back('{id: id, data: sh_rd(a), due: cyc + 2});
        q1.push_back('{id: id, data: sh_rd(a), due: cyc + 4});
    endtask

    task automatic check_inst(input int k);
        ent_t e;
        bit   hit = 1'b0;
        logic [2:0] ev = 3'b000;
        if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            hit = 1'b1;
        end else if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            hit = 1'b1;
        end
        if (hit) begin
            case (e.id)
                2'd0:    ev[0] = 1'b1;
                2'd1:    ev[1] = 1'b1;
                default: ev[2] = 1'b1;
            endcase
            held[k][e.id] = e.data;
        end
        chk($sformatf("disp_vld[lat%0d]", 2*k+1), 32'(disp_vld[k]), 32'(ev[0]));
        chk($sformatf("a_rvld[lat%0d]", 2*k+1), 32'(a_rvld[k]), 32'(ev[1]));
        chk($sformatf("b_rvld[lat%0d]", 2*k+1), 32'(b_rvld[k]), 32'(ev[2]));
        chk($sformatf("disp_data[lat%0d]", 2*k+1), 32'(disp_data[k]), 32'(held[k][0]));
        chk($sformatf("a_rdata[lat%0d]", 2*k+1), 32'(a_rdata[k]), 32'(held[k][1]));
        chk($sformatf("b_rdata[lat%0d]", 2*k+1), 32'(b_rdata[k]), 32'(held[k][2]));
    endtask

    // Scoreboard: decisions push expectations, returns pop and compare
    always @(negedge clk) begin
        logic open, dwin, ga, gb;
        cyc++;
        if (rst) begin
            ph_m = 2'd0;
            rr_m = 1'b0;
            q0.delete();
            q1.delete();
            exp_en = 1'b0;
            exp_we = 1'b0;
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 3; j++) held[k][j] = 8'h00;
                chk("rst_disp_vld", 32'(disp_vld[k]), 32'd0);
                chk("rst_a_rvld", 32'(a_rvld[k]), 32'd0);
                chk("rst_b_rvld", 32'(b_rvld[k]), 32'd0);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                chk("phase", 32'(phase[k]), 32'(ph_m));
                chk("mem_en", 32'(mem_en[k]), 32'(exp_en));
                chk("mem_we", 32'(mem_we[k]), 32'(exp_we));
                if (exp_en) chk("mem_addr", 32'(mem_addr[k]), 32'(exp_addr));
                if (exp_we) chk("mem_wdata", 32'(mem_wdata[k]), 32'(exp_wd));
                check_inst(k);
            end
            open = (ph_m != 2'd0) || (RECLAIM && !disp_req);
            dwin = (ph_m == 2'd0) && disp_req;
            ga   = open && a_req && (!b_req || !rr_m);
            gb   = open && b_req && (!a_req || rr_m);
            for (int k = 0; k < 2; k++) begin
                chk("a_gnt", 32'(a_gnt[k]), 32'(ga));
                chk("b_gnt", 32'(b_gnt[k]), 32'(gb));
            end
            exp_en = dwin || ga || gb;
            exp_we = (ga && a_we) || (gb && b_we);
            if (dwin) begin
                exp_addr = disp_addr;
                push_rd(2'd0, disp_addr);
            end else if (ga || gb) begin
                exp_addr = ga ? a_addr : b_addr;
                exp_wd   = ga ? a_wdata : b_wdata;
                if (exp_we) begin
                    sh[exp_addr]   = exp_wd;
                    sh_v[exp_addr] = 1'b1;
                end else begin
                    push_rd(ga ? 2'd1 : 2'd2, exp_addr);
                end
            end
            if (ga) rr_m = 1'b1;
            else if (gb) rr_m = 1'b0;
            ph_m = ph_m + 2'd1;
        end
    end

    task automatic acc(input bit is_b, input bit we, input logic [13:0] addr, input logic [7:0] wd);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = is_b ? b_gnt[0] : a_gnt[0];
        end
        chk("acc_grant_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic check_zero(input int k);
        chk("z_phase", 32'(phase[k]), 32'd0);
        chk("z_mem_en", 32'(mem_en[k]), 32'd0);
        chk("z_mem_we", 32'(mem_we[k]), 32'd0);
        chk("z_mem_addr", 32'(mem_addr[k]), 32'd0);
        chk("z_mem_wdata", 32'(mem_wdata[k]), 32'd0);
        chk("z_gnt", 32'({a_gnt[k], b_gnt[k]}), 32'd0);
        chk("z_vld", 32'({disp_vld[k], a_rvld[k], b_rvld[k]}), 32'd0);
        chk("z_data", 32'({disp_data[k], a_rdata[k], b_rdata[k]}), 32'd0);
    endtask

    initial begin
        bit got, prev, cur, have_prev, found;
        int n;
        rst = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        @(posedge clk); #1;
        rst = 1'b0;

        // A writes 0xC3 to 0x0010, then reads it back
        acc(1'b0, 1'b1, 14'h0010, 8'hC3);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = a_gnt[0];
        end
        chk("raw_grant", 32'(got), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk("raw_early_lat1", 32'(a_rvld[0]), 32'd0);
        @(negedge clk);
        chk("raw_rvld_lat1", 32'(a_rvld[0]), 32'd1);
        chk("raw_rdata_lat1", 32'(a_rdata[0]), 32'hC3);
        @(negedge clk);
        @(negedge clk);
        chk("raw_rvld_lat3", 32'(a_rvld[1]), 32'd1);
        chk("raw_rdata_lat3", 32'(a_rdata[1]), 32'hC3);

        // Reset while an A read is in flight
        acc(1'b0, 1'b0, 14'h0050, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        repeat (6) @(negedge clk);

        // Display-only stream at 0x0123
        acc(1'b0, 1'b1, 14'h0123, 8'h5A);
        @(posedge clk); #1;
        disp_req = 1'b1; disp_addr = 14'h0123;
        for (int p = 0; p < 3; p++) begin
            found = 1'b0;
            for (int i = 0; i < 8 && !found; i++) begin
                @(negedge clk);
                found = (phase[0] == 2'd0);
            end
            chk("disp_phase0_seen", 32'(found), 32'd1);
            @(negedge clk);
            chk("disp_mem_en_ph1", 32'(mem_en[0]), 32'd1);
            chk("disp_mem_addr_ph1", 32'(mem_addr[0]), 32'h0123);
            @(negedge clk);
            chk("disp_vld_ph2", 32'(disp_vld[0]), 32'd1);
            chk("disp_data_ph2", 32'(disp_data[0]), 32'h5A);
        end
        @(posedge clk); #1;
        disp_req = 1'b0;

        // A and B both requesting continuously
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0200;
        b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0300;
        have_prev = 1'b0;
        prev = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_gnt[0] || b_gnt[0]) begin
                cur = b_gnt[0];
                if (have_prev) chk("ab_alternate", 32'(cur), 32'(!prev));
                prev = cur;
                have_prev = 1'b1;
                n++;
            end
        end
        chk("ab_grant_count_ok", 32'(n >= 8), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;

        // A requests in phase 0 with the display idle
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            found = (phase[0] == 2'd3);
        end
        chk("phase3_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
        @(negedge clk);
        got = a_gnt[0];
        chk("ph0_a_gnt", 32'(got), 32'(RECLAIM));
        if (!got) begin
            @(negedge clk);
            chk("ph1_a_gnt", 32'(a_gnt[0]), 32'd1);
        end
        @(posedge clk); #1;
        a_req = 1'b0;

        // Display and A/B traffic interleaved (checked on both latencies)
        @(posedge clk); #1;
        disp_req = 1'b1; disp_addr = 14'h0123;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) disp_addr = 14'h0010;
            acc(i[0], (i % 3) == 0, 14'(i * 37 + 16), 8'(i * 29 + 3));
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
